// File: rtl/cdb_arbiter.sv
// Dual-lane common data bus arbiter: per-FU 2-entry result buffers, round-robin
// grant of up to two heads per cycle, branch squash/clear of buffered masks.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int VAL_W  = 32,
  parameter int BRAT_W = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][VAL_W-1:0]  fu_value,
  input  logic [NUM_FU-1:0][BRAT_W-1:0] fu_mask,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [BRAT_W-1:0]             brat_mis,
  input  logic [BRAT_W-1:0]             brat_clear,
  output logic                          cdb1_valid_out,
  output logic                          cdb2_valid_out,
  output logic [TAG_W-1:0]              cdb1_tag_out,
  output logic [TAG_W-1:0]              cdb2_tag_out,
  output logic [VAL_W-1:0]              cdb1_value_out,
  output logic [VAL_W-1:0]              cdb2_value_out
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [VAL_W-1:0]  value;
    logic [BRAT_W-1:0] mask;
  } entry_t;

  // Slot 0 is always the older entry; the buffer is compacted every edge.
  entry_t [NUM_FU-1:0][1:0] fifo_q, fifo_d;
  logic   [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic               cdb1_valid_q, cdb1_valid_d, cdb2_valid_q, cdb2_valid_d;
  logic [TAG_W-1:0]   cdb1_tag_q, cdb1_tag_d, cdb2_tag_q, cdb2_tag_d;
  logic [VAL_W-1:0]   cdb1_value_q, cdb1_value_d, cdb2_value_q, cdb2_value_d;

  logic [NUM_FU-1:0][1:0]       ok;
  logic [NUM_FU-1:0]            elig;
  logic [NUM_FU-1:0]            head_slot;
  logic [NUM_FU-1:0][TAG_W-1:0] head_tag;
  logic [NUM_FU-1:0][VAL_W-1:0] head_value;
  logic [NUM_FU-1:0]            grant;
  logic [NUM_FU-1:0]            accept;

  assign cdb1_valid_out = cdb1_valid_q;
  assign cdb2_valid_out = cdb2_valid_q;
  assign cdb1_tag_out   = cdb1_tag_q;
  assign cdb2_tag_out   = cdb2_tag_q;
  assign cdb1_value_out = cdb1_value_q;
  assign cdb2_value_out = cdb2_value_q;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !(fifo_q[i][0].valid && fifo_q[i][1].valid);
      accept[i]   = fu_valid[i] && fu_ready[i] && ((fu_mask[i] & brat_mis) == '0);
    end
  end

  // Squashed entries are skipped, so the head may be the younger slot.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      ok[i][0]      = fifo_q[i][0].valid && ((fifo_q[i][0].mask & brat_mis) == '0);
      ok[i][1]      = fifo_q[i][1].valid && ((fifo_q[i][1].mask & brat_mis) == '0);
      elig[i]       = ok[i][0] || ok[i][1];
      head_slot[i]  = !ok[i][0];
      head_tag[i]   = ok[i][0] ? fifo_q[i][0].tag   : fifo_q[i][1].tag;
      head_value[i] = ok[i][0] ? fifo_q[i][0].value : fifo_q[i][1].value;
    end
  end

  always_comb begin : arb
    logic             g1, g2;
    logic [PTR_W-1:0] g1_idx, g2_idx, last, idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    g1       = 1'b0;
    g2       = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    last     = rr_ptr_q;
    idx      = '0;
    grant    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
      if (elig[idx]) begin
        if (!g1) begin
          g1 = 1'b1; g1_idx = idx; grant[idx] = 1'b1; last = idx;
        end else if (!g2) begin
          g2 = 1'b1; g2_idx = idx; grant[idx] = 1'b1; last = idx;
        end
      end
    end
    rr_ptr_d     = g1 ? PTR_W'((int'(last) + 1) % NUM_FU) : rr_ptr_q;
    cdb1_valid_d = g1;
    cdb1_tag_d   = g1 ? head_tag[g1_idx]   : cdb1_tag_q;
    cdb1_value_d = g1 ? head_value[g1_idx] : cdb1_value_q;
    cdb2_valid_d = g2;
    cdb2_tag_d   = g2 ? head_tag[g2_idx]   : cdb2_tag_q;
    cdb2_value_d = g2 ? head_value[g2_idx] : cdb2_value_q;
  end

  // Survivors keep their order; a new arrival always lands behind them.
  always_comb begin : fifo_next
    entry_t e0, e1, inc;
    logic   keep0, keep1;
    fifo_d = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      keep0     = ok[i][0] && !(grant[i] && !head_slot[i]);
      keep1     = ok[i][1] && !(grant[i] && head_slot[i]);
      e0        = fifo_q[i][0];
      e0.mask   = e0.mask & ~brat_clear;
      e1        = fifo_q[i][1];
      e1.mask   = e1.mask & ~brat_clear;
      inc.valid = 1'b1;
      inc.tag   = fu_tag[i];
      inc.value = fu_value[i];
      inc.mask  = fu_mask[i] & ~brat_clear;
      if (keep0) begin
        fifo_d[i][0] = e0;
        if (keep1)          fifo_d[i][1] = e1;
        else if (accept[i]) fifo_d[i][1] = inc;
      end else if (keep1) begin
        fifo_d[i][0] = e1;
        if (accept[i]) fifo_d[i][1] = inc;
      end else if (accept[i]) begin
        fifo_d[i][0] = inc;
      end
    end
  end

  // NOTE: the buffers are a handful of flops, so they are reset outright; valid bits alone would suffice for a RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q       <= '0;
      rr_ptr_q     <= '0;
      cdb1_valid_q <= 1'b0;
      cdb2_valid_q <= 1'b0;
      cdb1_tag_q   <= '0;
      cdb2_tag_q   <= '0;
      cdb1_value_q <= '0;
      cdb2_value_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      fifo_q       <= fifo_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb1_valid_q <= cdb1_valid_d;
      cdb2_valid_q <= cdb2_valid_d;
      cdb1_tag_q   <= cdb1_tag_d;
      cdb2_tag_q   <= cdb2_tag_d;
      cdb1_value_q <= cdb1_value_d;
      cdb2_value_q <= cdb2_value_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, backpressure,
// squash, mask clear and mid-operation reset.
module tb_cdb_arbiter;

  logic             clock, reset;
  logic [3:0]       fu_valid;
  logic [3:0][4:0]  fu_tag;
  logic [3:0][31:0] fu_value;
  logic [3:0][3:0]  fu_mask;
  logic [3:0]       fu_ready;
  logic [3:0]       brat_mis, brat_clear;
  logic             cdb1_valid_out, cdb2_valid_out;
  logic [4:0]       cdb1_tag_out, cdb2_tag_out;
  logic [31:0]      cdb1_value_out, cdb2_value_out;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_FU(4), .TAG_W(5), .VAL_W(32), .BRAT_W(4)) dut (
    .clock(clock), .reset(reset),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_mask(fu_mask),
    .fu_ready(fu_ready), .brat_mis(brat_mis), .brat_clear(brat_clear),
    .cdb1_valid_out(cdb1_valid_out), .cdb2_valid_out(cdb2_valid_out),
    .cdb1_tag_out(cdb1_tag_out), .cdb2_tag_out(cdb2_tag_out),
    .cdb1_value_out(cdb1_value_out), .cdb2_value_out(cdb2_value_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs;
    fu_valid = '0; fu_tag = '0; fu_value = '0; fu_mask = '0;
    brat_mis = '0; brat_clear = '0;
  endtask

  task automatic put(input int i, input logic [4:0] t, input logic [31:0] v, input logic [3:0] m);
    fu_valid[i] = 1'b1; fu_tag[i] = t; fu_value[i] = v; fu_mask[i] = m;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    #3;
    checks++; if ({cdb1_valid_out, cdb2_valid_out} !== 2'b00) begin failures++;
      $display("FAIL reset_valid: got %b want 00", {cdb1_valid_out, cdb2_valid_out}); end
    checks++; if ({cdb1_tag_out, cdb2_tag_out, cdb1_value_out, cdb2_value_out} !== '0) begin failures++;
      $display("FAIL reset_data: got t1=%0d t2=%0d v1=%h v2=%h want 0", cdb1_tag_out, cdb2_tag_out, cdb1_value_out, cdb2_value_out); end
    checks++; if (fu_ready !== 4'hF) begin failures++;
      $display("FAIL reset_ready: got %b want 1111", fu_ready); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    put(0, 5'd3, 32'h11, 4'h0);
    tick();
    fu_valid = '0;
    checks++; if (cdb1_valid_out !== 1'b0) begin failures++;
      $display("FAIL single_early: got %b want 0", cdb1_valid_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb1_value_out} !== {1'b1, 5'd3, 32'h11}) begin failures++;
      $display("FAIL single_lane1: got v=%b t=%0d val=%h want v=1 t=3 val=11", cdb1_valid_out, cdb1_tag_out, cdb1_value_out); end
    checks++; if (cdb2_valid_out !== 1'b0) begin failures++;
      $display("FAIL single_lane2: got %b want 0", cdb2_valid_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out} !== {1'b0, 5'd3}) begin failures++;
      $display("FAIL single_hold: got v=%b t=%0d want v=0 t=3", cdb1_valid_out, cdb1_tag_out); end
  endtask

  task automatic test_round_robin;
    do_reset();
    put(0, 5'd1, 32'h101, 4'h0); put(1, 5'd2, 32'h102, 4'h0); put(2, 5'd3, 32'h103, 4'h0);
    tick();
    fu_valid = '0;
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin failures++;
      $display("FAIL rr_cycle1: got v1=%b t1=%0d v2=%b t2=%0d want 1/1 1/2", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out); end
    checks++; if (cdb2_value_out !== 32'h102) begin failures++;
      $display("FAIL rr_value2: got %h want 102", cdb2_value_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out} !== {1'b1, 5'd3, 1'b0}) begin failures++;
      $display("FAIL rr_cycle2: got v1=%b t1=%0d v2=%b want 1/3 0", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out); end
    // pointer should now sit at 3: FU3 must win lane 1 over FU0
    put(0, 5'd4, 32'h104, 4'h0); put(3, 5'd8, 32'h108, 4'h0);
    tick();
    fu_valid = '0;
    tick();
    checks++; if ({cdb1_tag_out, cdb2_tag_out, cdb1_valid_out, cdb2_valid_out} !== {5'd8, 5'd4, 2'b11}) begin failures++;
      $display("FAIL rr_ptr3: got t1=%0d t2=%0d v=%b%b want 8 4 11", cdb1_tag_out, cdb2_tag_out, cdb1_valid_out, cdb2_valid_out); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    put(0, 5'd20, 32'h120, 4'h0); put(1, 5'd21, 32'h121, 4'h0); put(3, 5'd5, 32'h105, 4'h0);
    tick();
    checks++; if (fu_ready !== 4'hF) begin failures++;
      $display("FAIL b2b_ready1: got %b want 1111", fu_ready); end
    put(0, 5'd22, 32'h122, 4'h0); put(1, 5'd23, 32'h123, 4'h0); put(3, 5'd6, 32'h106, 4'h0);
    tick();
    checks++; if ({cdb1_tag_out, cdb2_tag_out} !== {5'd20, 5'd21}) begin failures++;
      $display("FAIL b2b_e2: got t1=%0d t2=%0d want 20 21", cdb1_tag_out, cdb2_tag_out); end
    checks++; if (fu_ready !== 4'b0111) begin failures++;
      $display("FAIL b2b_full: got %b want 0111", fu_ready); end
    fu_valid[0] = 1'b0; fu_valid[1] = 1'b0;
    put(3, 5'd7, 32'h107, 4'h0);
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out} !== {1'b1, 5'd5, 1'b1, 5'd22}) begin failures++;
      $display("FAIL b2b_e3: got v1=%b t1=%0d v2=%b t2=%0d want 1/5 1/22", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out); end
    tick();
    fu_valid = '0;
    checks++; if ({cdb1_tag_out, cdb2_tag_out, cdb1_valid_out, cdb2_valid_out} !== {5'd23, 5'd6, 2'b11}) begin failures++;
      $display("FAIL b2b_e4: got t1=%0d t2=%0d v=%b%b want 23 6 11", cdb1_tag_out, cdb2_tag_out, cdb1_valid_out, cdb2_valid_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb1_value_out, cdb2_valid_out} !== {1'b1, 5'd7, 32'h107, 1'b0}) begin failures++;
      $display("FAIL b2b_e5: got v1=%b t1=%0d val=%h v2=%b want 1/7/107 0", cdb1_valid_out, cdb1_tag_out, cdb1_value_out, cdb2_valid_out); end
  endtask

  task automatic test_squash;
    do_reset();
    put(1, 5'd1, 32'h101, 4'h0);
    tick();
    put(1, 5'd9, 32'h109, 4'b0010); put(2, 5'd30, 32'h130, 4'h0); put(3, 5'd31, 32'h131, 4'h0);
    tick();
    put(1, 5'd10, 32'h110, 4'h0); put(2, 5'd32, 32'h132, 4'h0); put(3, 5'd33, 32'h133, 4'h0);
    tick();
    checks++; if ({cdb1_tag_out, cdb2_tag_out} !== {5'd30, 5'd31}) begin failures++;
      $display("FAIL squash_pre: got t1=%0d t2=%0d want 30 31", cdb1_tag_out, cdb2_tag_out); end
    fu_valid = '0;
    brat_mis = 4'b0010;
    put(0, 5'd12, 32'h112, 4'b0010);
    tick();
    fu_valid = '0;
    brat_mis = '0;
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out} !== {1'b1, 5'd10, 1'b1, 5'd32}) begin failures++;
      $display("FAIL squash_skip: got v1=%b t1=%0d v2=%b t2=%0d want 1/10 1/32", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out} !== {1'b1, 5'd33, 1'b0}) begin failures++;
      $display("FAIL squash_drop: got v1=%b t1=%0d v2=%b want 1/33 0", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb2_valid_out} !== 2'b00) begin failures++;
      $display("FAIL squash_empty: got %b%b want 00", cdb1_valid_out, cdb2_valid_out); end
  endtask

  task automatic test_clear;
    do_reset();
    put(0, 5'd40, 32'h140, 4'h0); put(1, 5'd41, 32'h141, 4'h0); put(2, 5'd42, 32'h142, 4'b0110);
    tick();
    fu_valid[2] = 1'b0;
    put(0, 5'd43, 32'h143, 4'h0); put(1, 5'd44, 32'h144, 4'h0);
    brat_clear = 4'b0100;
    tick();
    fu_valid = '0;
    brat_clear = '0;
    brat_mis = 4'b0100;
    checks++; if ({cdb1_tag_out, cdb2_tag_out} !== {5'd40, 5'd41}) begin failures++;
      $display("FAIL clear_pre: got t1=%0d t2=%0d want 40 41", cdb1_tag_out, cdb2_tag_out); end
    tick();
    brat_mis = '0;
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out} !== {1'b1, 5'd42, 1'b1, 5'd43}) begin failures++;
      $display("FAIL clear_survive: got v1=%b t1=%0d v2=%b t2=%0d want 1/42 1/43", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out, cdb2_tag_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb1_tag_out, cdb2_valid_out} !== {1'b1, 5'd44, 1'b0}) begin failures++;
      $display("FAIL clear_tail: got v1=%b t1=%0d v2=%b want 1/44 0", cdb1_valid_out, cdb1_tag_out, cdb2_valid_out); end
    // mispredict wins over clear on the same bit
    put(0, 5'd50, 32'h150, 4'b0001);
    tick();
    fu_valid = '0;
    brat_mis = 4'b0001; brat_clear = 4'b0001;
    tick();
    brat_mis = '0; brat_clear = '0;
    checks++; if (cdb1_valid_out !== 1'b0) begin failures++;
      $display("FAIL clear_prec: got v1=%b t1=%0d want v1=0", cdb1_valid_out, cdb1_tag_out); end
    tick();
    checks++; if ({cdb1_valid_out, cdb2_valid_out} !== 2'b00) begin failures++;
      $display("FAIL clear_prec_late: got %b%b want 00", cdb1_valid_out, cdb2_valid_out); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    put(0, 5'd60, 32'h160, 4'h0); put(1, 5'd61, 32'h161, 4'h0);
    put(2, 5'd62, 32'h162, 4'h0); put(3, 5'd63, 32'h163, 4'h0);
    tick();
    fu_valid = '0;
    put(0, 5'd64, 32'h164, 4'h0); put(1, 5'd65, 32'h165, 4'h0);
    tick();
    fu_valid = '0;
    checks++; if ({cdb1_tag_out, cdb2_tag_out, cdb1_valid_out, cdb2_valid_out} !== {5'd60, 5'd61, 2'b11}) begin failures++;
      $display("FAIL rmid_pre: got t1=%0d t2=%0d v=%b%b want 60 61 11", cdb1_tag_out, cdb2_tag_out, cdb1_valid_out, cdb2_valid_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cdb1_valid_out, cdb2_valid_out, cdb1_tag_out, cdb2_tag_out, cdb1_value_out, cdb2_value_out} !== '0) begin failures++;
      $display("FAIL rmid_async: got v=%b%b t1=%0d t2=%0d want all 0", cdb1_valid_out, cdb2_valid_out, cdb1_tag_out, cdb2_tag_out); end
    checks++; if (fu_ready !== 4'hF) begin failures++;
      $display("FAIL rmid_ready: got %b want 1111", fu_ready); end
    #1 reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if ({cdb1_valid_out, cdb2_valid_out} !== 2'b00) begin failures++;
        $display("FAIL rmid_stale%0d: got v=%b%b t1=%0d t2=%0d want v=00", n, cdb1_valid_out, cdb2_valid_out, cdb1_tag_out, cdb2_tag_out); end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_squash();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
